// File: rtl/vcmd_decoder.sv
// Byte-stream command decoder for the framebuffer write path: tracks the cursor
// and increment mode, emits pixel writes and raises buffer-swap requests.
module vcmd_decoder #(
  parameter int unsigned PixW = 4,
  parameter int unsigned XW   = 10,
  parameter int unsigned YW   = 9,
  parameter int unsigned HRes = 640,
  parameter int unsigned VRes = 480
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            CmdValid,
  output logic            CmdReady,
  input  logic [7:0]      CmdIn,
  output logic            PixValid,
  input  logic            PixReady,
  output logic [XW-1:0]   PixX,
  output logic [YW-1:0]   PixY,
  output logic [PixW-1:0] PixData,
  output logic            SwapReq,
  input  logic            SwapAck,
  output logic            CmdErr
);

  typedef enum logic [3:0] {
    S_IDLE, S_READXH, S_READXL, S_READYH, S_READYL,
    S_READCOUNT, S_READDATA, S_EMITPIX, S_WAITSWAP
  } state_t;

  localparam logic [XW-1:0] XLast = XW'(HRes - 1);
  localparam logic [YW-1:0] YLast = YW'(VRes - 1);
  localparam logic [2:0]    GLast = 3'(8 / PixW - 1);

  state_t          state, state_n;
  logic [XW-1:0]   x, x_n, xadv;
  logic [YW-1:0]   y, y_n, yadv;
  logic            inc, inc_n;
  logic [7:0]      hi, hi_n;
  logic [8:0]      count, count_n;
  logic            pk, pk_n;
  logic [7:0]      sh, sh_n;
  logic [2:0]      grp, grp_n;
  logic            pv_n, sr_n, err_n, rdy_n;
  logic [XW-1:0]   px_n;
  logic [YW-1:0]   py_n;
  logic [PixW-1:0] pd_n;
  logic            fire;
  logic [15:0]     word;

  assign fire = CmdValid & CmdReady;
  assign word = {hi, CmdIn};

  always_comb begin
    xadv = x;
    yadv = y;
    if (x == XLast) begin
      xadv = '0;
      yadv = (y == YLast) ? '0 : y + 1'b1;
    end else begin
      xadv = x + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    inc_n   = inc;
    hi_n    = hi;
    count_n = count;
    pk_n    = pk;
    sh_n    = sh;
    grp_n   = grp;
    pv_n    = PixValid;
    px_n    = PixX;
    py_n    = PixY;
    pd_n    = PixData;
    sr_n    = SwapReq;
    err_n   = 1'b0;
    case (state)
      S_IDLE: if (fire) begin
        case (CmdIn)
          8'h00: ;
          8'h01: begin sr_n = 1'b1; state_n = S_WAITSWAP; end
          8'h10: inc_n = 1'b0;
          8'h11: inc_n = 1'b1;
          8'h12: begin x_n = '0; y_n = '0; end
          8'h20: state_n = S_READXH;
          8'h30: state_n = S_READYH;
          8'h40, 8'h41: begin
            pk_n = CmdIn[0]; count_n = 9'd1; state_n = S_READDATA;
          end
          8'h42, 8'h43: begin pk_n = CmdIn[0]; state_n = S_READCOUNT; end
          default: err_n = 1'b1;
        endcase
      end
      S_READXH: if (fire) begin hi_n = CmdIn; state_n = S_READXL; end
      S_READXL: if (fire) begin
        if (word >= 16'(HRes)) err_n = 1'b1;
        else x_n = word[XW-1:0];
        state_n = S_IDLE;
      end
      S_READYH: if (fire) begin hi_n = CmdIn; state_n = S_READYL; end
      S_READYL: if (fire) begin
        if (word >= 16'(VRes)) err_n = 1'b1;
        else y_n = word[YW-1:0];
        state_n = S_IDLE;
      end
      S_READCOUNT: if (fire) begin
        count_n = (CmdIn == 8'd0) ? 9'd256 : {1'b0, CmdIn};
        state_n = S_READDATA;
      end
      S_READDATA: if (fire) begin
        count_n = count - 9'd1;
        sh_n    = CmdIn >> PixW;
        grp_n   = '0;
        pv_n    = 1'b1;
        px_n    = x;
        py_n    = y;
        pd_n    = CmdIn[PixW-1:0];
        state_n = S_EMITPIX;
      end
      S_EMITPIX: if (PixReady) begin
        if (inc) begin x_n = xadv; y_n = yadv; end
        // packed groups reuse the post-handshake cursor directly
        if (pk && grp != GLast) begin
          grp_n = grp + 1'b1;
          pd_n  = sh[PixW-1:0];
          sh_n  = sh >> PixW;
          px_n  = inc ? xadv : x;
          py_n  = inc ? yadv : y;
        end else begin
          pv_n    = 1'b0;
          state_n = (count != 9'd0) ? S_READDATA : S_IDLE;
        end
      end
      S_WAITSWAP: if (SwapAck) begin sr_n = 1'b0; state_n = S_IDLE; end
      default: state_n = S_IDLE;
    endcase
    rdy_n = !(state_n == S_EMITPIX || state_n == S_WAITSWAP);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      x        <= '0;
      y        <= '0;
      inc      <= 1'b0;
      hi       <= '0;
      count    <= '0;
      pk       <= 1'b0;
      sh       <= '0;
      grp      <= '0;
      CmdReady <= 1'b0;
      PixValid <= 1'b0;
      PixX     <= '0;
      PixY     <= '0;
      PixData  <= '0;
      SwapReq  <= 1'b0;
      CmdErr   <= 1'b0;
    end else begin
      state    <= state_n;
      x        <= x_n;
      y        <= y_n;
      inc      <= inc_n;
      hi       <= hi_n;
      count    <= count_n;
      pk       <= pk_n;
      sh       <= sh_n;
      grp      <= grp_n;
      CmdReady <= rdy_n;
      PixValid <= pv_n;
      PixX     <= px_n;
      PixY     <= py_n;
      PixData  <= pd_n;
      SwapReq  <= sr_n;
      CmdErr   <= err_n;
    end
  end

endmodule

// File: tb/tb_vcmd_decoder.sv
// Directed bench for vcmd_decoder with hand-computed expected pixels, errors and swaps.
module tb_vcmd_decoder;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       CmdValid = 1'b0;
  logic       CmdReady;
  logic [7:0] CmdIn = 8'h00;
  logic       PixValid;
  logic       PixReady = 1'b0;
  logic [9:0] PixX;
  logic [8:0] PixY;
  logic [3:0] PixData;
  logic       SwapReq;
  logic       SwapAck = 1'b0;
  logic       CmdErr;

  int tests = 0;
  int fails = 0;

  vcmd_decoder #(.PixW(4), .XW(10), .YW(9), .HRes(640), .VRes(480)) dut (
    .Clk(Clk), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdIn(CmdIn), .PixValid(PixValid), .PixReady(PixReady), .PixX(PixX),
    .PixY(PixY), .PixData(PixData), .SwapReq(SwapReq), .SwapAck(SwapAck),
    .CmdErr(CmdErr)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bit done = 0;
    while (!done && n < 200) begin
      @(negedge Clk);
      if (CmdReady) begin
        CmdValid = 1'b1;
        CmdIn    = b;
        @(posedge Clk);
        #1 CmdValid = 1'b0;
        done = 1;
      end
      n++;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_pix(input string tag, input int ex, input int ey, input int ed,
                            input int hold);
    int n = 0;
    @(negedge Clk);
    while (!PixValid && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check({tag, ".valid"}, 32'(PixValid), 32'd1);
    check({tag, ".x"}, 32'(PixX), 32'(ex));
    check({tag, ".y"}, 32'(PixY), 32'(ey));
    check({tag, ".data"}, 32'(PixData), 32'(ed));
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      check({tag, ".hold_valid"}, 32'(PixValid), 32'd1);
      check({tag, ".hold_x"}, 32'(PixX), 32'(ex));
      check({tag, ".hold_data"}, 32'(PixData), 32'(ed));
    end
    PixReady = 1'b1;
    @(posedge Clk);
    #1 PixReady = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    check("rst.ready", 32'(CmdReady), 32'd0);
    check("rst.pixvalid", 32'(PixValid), 32'd0);
    check("rst.swapreq", 32'(SwapReq), 32'd0);
    check("rst.err", 32'(CmdErr), 32'd0);
    check("rst.pix", {PixX, PixY, PixData}, 32'd0);
    @(negedge Clk) Reset = 1'b0;

    // Reset during a 4-byte burst after two data bytes
    send_byte(8'h42); send_byte(8'h04); send_byte(8'h01);
    expect_pix("t1.p0", 0, 0, 1, 0);
    send_byte(8'h02);
    @(negedge Clk) Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("t1.rst_pixvalid", 32'(PixValid), 32'd0);
    check("t1.rst_ready", 32'(CmdReady), 32'd0);
    check("t1.rst_pix", {PixX, PixY, PixData}, 32'd0);
    @(negedge Clk) Reset = 1'b0;
    send_byte(8'h00);
    @(negedge Clk);
    check("t1.noop_ready", 32'(CmdReady), 32'd1);
    check("t1.noop_pixvalid", 32'(PixValid), 32'd0);

    // SetX/SetY and out-of-range X
    send_byte(8'h20); send_byte(8'h01); send_byte(8'h3F);
    send_byte(8'h30); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'h40); send_byte(8'h07);
    expect_pix("t2.a", 319, 16, 7, 0);
    send_byte(8'h20); send_byte(8'h02); send_byte(8'h80);
    check("t2.err_pulse", 32'(CmdErr), 32'd1);
    @(posedge Clk);
    #1 check("t2.err_clear", 32'(CmdErr), 32'd0);
    send_byte(8'h40); send_byte(8'h03);
    expect_pix("t2.b", 319, 16, 3, 0);

    // Packed write across the full-frame wrap
    send_byte(8'h11);
    send_byte(8'h20); send_byte(8'h02); send_byte(8'h7F);
    send_byte(8'h30); send_byte(8'h01); send_byte(8'hDF);
    send_byte(8'h41); send_byte(8'hA5);
    expect_pix("t3.p0", 639, 479, 5, 0);
    expect_pix("t3.p1", 0, 0, 10, 0);
    @(negedge Clk);
    check("t3.done_pixvalid", 32'(PixValid), 32'd0);

    // Unpacked burst, no increment, back-pressure (cursor now (1,0))
    send_byte(8'h10);
    send_byte(8'h42); send_byte(8'h03); send_byte(8'h01);
    expect_pix("t4.p0", 1, 0, 1, 2);
    send_byte(8'h02);
    expect_pix("t4.p1", 1, 0, 2, 1);
    send_byte(8'h03);
    expect_pix("t4.p2", 1, 0, 3, 2);

    // Buffer swap with ack on the fifth high cycle
    send_byte(8'h01);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("t5.swapreq_high", 32'(SwapReq), 32'd1);
      check("t5.ready_low", 32'(CmdReady), 32'd0);
    end
    SwapAck = 1'b1;
    @(posedge Clk);
    #1 SwapAck = 1'b0;
    check("t5.swapreq_drop", 32'(SwapReq), 32'd0);
    @(negedge Clk);
    check("t5.idle_ready", 32'(CmdReady), 32'd1);
    SwapAck = 1'b1;
    @(negedge Clk) SwapAck = 1'b0;
    @(negedge Clk);
    check("t5.stray_ack", 32'(SwapReq), 32'd0);

    // Unknown opcode, then Set0
    send_byte(8'h7E);
    check("t6.err_pulse", 32'(CmdErr), 32'd1);
    @(posedge Clk);
    #1 check("t6.err_clear", 32'(CmdErr), 32'd0);
    send_byte(8'h40); send_byte(8'h04);
    expect_pix("t6.nochange", 1, 0, 4, 0);
    send_byte(8'h12);
    send_byte(8'h40); send_byte(8'h09);
    expect_pix("t6.set0", 0, 0, 9, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
